// File: rtl/isa_pkg.sv
// Shared ISA-level widths, encodings and types used by fetch, instruction
// memory and decode.
package isa_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam instr_t HALT_INSTR = 16'hF000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// holds the IF/ID register handed to decode over a valid/ready handshake.
module fetch_stage
  import isa_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imemAdr,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] instrOut,
  output logic [ADDR_W-1:0]  instrPc,
  output logic               instrValid,
  input  logic               decodeReady,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  output logic               halted,
  output logic [CNT_W-1:0]   fetchCount
);

  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  instr_t       instr_out_q, instr_out_d;
  addr_t        instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  cnt_t         fetch_count_q, fetch_count_d;
  logic         fire;

  assign fire = (state_q == RUN) && !branchTaken && (!instr_valid_q || decodeReady);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    if (branchTaken) begin
      // A halt seen before the branch resolved is wrong-path, so leave HALTED.
      pc_d          = branchTarget;
      instr_valid_d = 1'b0;
      state_d       = RUN;
    end else if (fire) begin
      instr_out_d   = imemData;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      if (fetch_count_q != '1) fetch_count_d = fetch_count_q + cnt_t'(1);
      if (imemData == HALT_INSTR) state_d = HALTED;
      else                        pc_d    = pc_q + addr_t'(1);
    end else if (state_q == HALTED && instr_valid_q && decodeReady) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imemAdr    = pc_q;
  assign instrOut   = instr_out_q;
  assign instrPc    = instr_pc_q;
  assign instrValid = instr_valid_q;
  assign halted     = (state_q == HALTED);
  assign fetchCount = fetch_count_q;

endmodule
